// File: rtl/evg_dbus_pkg.sv
// Shared types and sizing helpers for the EVG distributed bus generator.
package evg_dbus_pkg;

   localparam int unsigned MODE_WIDTH = 3;
   localparam int unsigned ADDR_WIDTH = 5;

   typedef enum logic [MODE_WIDTH-1:0] {
      MODE_STATIC       = 3'd0,
      MODE_HEARTBEAT    = 3'd1,
      MODE_DIVIDER      = 3'd2,
      MODE_DIVIDER_SYNC = 3'd3,
      MODE_INPUT        = 3'd4,
      MODE_SEQ_PULSE    = 3'd5,
      MODE_RSVD6        = 3'd6,
      MODE_RSVD7        = 3'd7
   } dbus_mode_e;

   // Heartbeat interval counter width: enough for a few seconds of tx clock.
   function automatic int unsigned hb_width(input int unsigned nominal_freq);
      return 32'($clog2(nominal_freq)) + 32'd2;
   endfunction

   // Width of a {mode, param} configuration word.
   function automatic int unsigned cfg_width(input int unsigned div_width);
      return MODE_WIDTH + div_width;
   endfunction

endpackage

// File: rtl/evg_dbus_channel.sv
// One distributed bus bit: config storage, counter/toggle state, registered output.
module evg_dbus_channel
   import evg_dbus_pkg::*;
#(
   parameter int unsigned DIV_WIDTH       = 24,
   parameter int unsigned EXT_INPUT_COUNT = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wr_en_i,
   input  logic [MODE_WIDTH-1:0]      wr_mode_i,
   input  logic [DIV_WIDTH-1:0]       wr_param_i,
   input  logic                       hb_out_i,
   input  logic                       hb_strobe_i,
   input  logic                       seq_start_i,
   input  logic [EXT_INPUT_COUNT-1:0] ext_sync_i,
   output logic [MODE_WIDTH-1:0]      cfg_mode_o,
   output logic [DIV_WIDTH-1:0]       cfg_param_o,
   output logic                       bus_o
);

   localparam int unsigned SEL_WIDTH = (EXT_INPUT_COUNT > 1) ? $clog2(EXT_INPUT_COUNT) : 1;

   dbus_mode_e           mode_q, mode_d;
   logic [DIV_WIDTH-1:0] param_q, param_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic                 tgl_q, tgl_d;
   logic                 bus_q;
   logic                 out_c;
   logic [SEL_WIDTH-1:0] sel_c;

   // External input selected by the low part of param (modulo input count)
   assign sel_c = SEL_WIDTH'(param_q % DIV_WIDTH'(EXT_INPUT_COUNT));

   // Next config, counter and toggle state; a config write restarts from phase 0
   always_comb begin
      mode_d  = mode_q;
      param_d = param_q;
      cnt_d   = cnt_q;
      tgl_d   = tgl_q;
      if (wr_en_i) begin
         mode_d  = dbus_mode_e'(wr_mode_i);
         param_d = wr_param_i;
         cnt_d   = '0;
         tgl_d   = 1'b0;
      end else begin
         unique case (mode_q)
            MODE_DIVIDER_SYNC: begin
               if (hb_strobe_i) begin
                  cnt_d = param_q;
                  tgl_d = 1'b1;
               end else if (cnt_q == '0) begin
                  cnt_d = param_q;
                  tgl_d = ~tgl_q;
               end else begin
                  cnt_d = cnt_q - DIV_WIDTH'(1);
               end
            end
            MODE_DIVIDER: begin
               if (cnt_q == '0) begin
                  cnt_d = param_q;
                  tgl_d = ~tgl_q;
               end else begin
                  cnt_d = cnt_q - DIV_WIDTH'(1);
               end
            end
            MODE_SEQ_PULSE: begin
               if (seq_start_i) begin
                  cnt_d = param_q;
                  tgl_d = 1'b1;
               end else if (tgl_q) begin
                  if (cnt_q == '0) begin
                     tgl_d = 1'b0;
                  end else begin
                     cnt_d = cnt_q - DIV_WIDTH'(1);
                  end
               end
            end
            default: begin
               cnt_d = cnt_q;
               tgl_d = tgl_q;
            end
         endcase
      end
   end

   // Channel state presented to the bus register
   always_comb begin
      out_c = 1'b0;
      unique case (mode_q)
         MODE_STATIC:       out_c = param_q[0];
         MODE_HEARTBEAT:    out_c = hb_out_i;
         MODE_DIVIDER,
         MODE_DIVIDER_SYNC,
         MODE_SEQ_PULSE:    out_c = tgl_q;
         MODE_INPUT:        out_c = ext_sync_i[sel_c];
         default:           out_c = 1'b0;
      endcase
   end

   // Config, counter, toggle and bus registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q  <= MODE_STATIC;
         param_q <= '0;
         cnt_q   <= '0;
         tgl_q   <= 1'b0;
         bus_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         param_q <= param_d;
         cnt_q   <= cnt_d;
         tgl_q   <= tgl_d;
         bus_q   <= out_c;
      end
   end

   assign cfg_mode_o  = mode_q;
   assign cfg_param_o = param_q;
   assign bus_o       = bus_q;

endmodule

// File: rtl/evg_dbus_generator.sv
// Per-bit programmable EVG distributed bus source: heartbeat tracker,
// input synchronisers, config readback and one channel per bus bit.
module evg_dbus_generator
   import evg_dbus_pkg::*;
#(
   parameter int unsigned DISTRIBUTED_BUS_WIDTH   = 8,
   parameter int unsigned TXCLK_NOMINAL_FREQUENCY = 125000000,
   parameter int unsigned DIV_WIDTH               = 24,
   parameter int unsigned EXT_INPUT_COUNT         = 4
) (
   input  logic                               evgTxClk,
   input  logic                               evgRst_n,
   input  logic                               evgHeartbeatRequest,
   input  logic                               evgSequenceStart,
   input  logic [EXT_INPUT_COUNT-1:0]         extIn_a,
   input  logic                               cfgWriteStrobe,
   input  logic [ADDR_WIDTH-1:0]              cfgAddress,
   input  logic [cfg_width(DIV_WIDTH)-1:0]    cfgWriteData,
   output logic [cfg_width(DIV_WIDTH)-1:0]    cfgReadData,
   output logic [DISTRIBUTED_BUS_WIDTH-1:0]   evgDistributedBus
);

   localparam int unsigned HB_WIDTH  = hb_width(TXCLK_NOMINAL_FREQUENCY);
   localparam int unsigned CFG_WIDTH = cfg_width(DIV_WIDTH);

   logic [HB_WIDTH-1:0] hb_interval_q, hb_interval_d;
   logic [HB_WIDTH-1:0] hb_ext_q, hb_ext_d;
   logic                hb_out_q, hb_out_d;
   logic                hb_sat_c;

   (* ASYNC_REG = "TRUE" *) logic [EXT_INPUT_COUNT-1:0] ext_meta_q;
   (* ASYNC_REG = "TRUE" *) logic [EXT_INPUT_COUNT-1:0] ext_sync_q;

   logic [CFG_WIDTH-1:0]  rd_q, rd_d;
   logic [MODE_WIDTH-1:0] ch_mode  [DISTRIBUTED_BUS_WIDTH];
   logic [DIV_WIDTH-1:0]  ch_param [DISTRIBUTED_BUS_WIDTH];
   logic [DISTRIBUTED_BUS_WIDTH-1:0] ch_bus;

   assign hb_sat_c = (hb_interval_q == '1);

   // Heartbeat tracker: saturating interval counter, pulse stretched to half the last interval
   always_comb begin
      hb_interval_d = hb_sat_c ? hb_interval_q : hb_interval_q + HB_WIDTH'(1);
      hb_ext_d      = hb_ext_q;
      hb_out_d      = hb_out_q;
      if (evgHeartbeatRequest) begin
         hb_interval_d = '0;
      end
      if (evgHeartbeatRequest && !hb_sat_c) begin
         hb_ext_d = hb_interval_q >> 1;
         hb_out_d = 1'b1;
      end else if (hb_ext_q != '0) begin
         hb_ext_d = hb_ext_q - HB_WIDTH'(1);
      end else begin
         hb_out_d = 1'b0;
      end
   end

   // Heartbeat tracker registers
   always_ff @(posedge evgTxClk or negedge evgRst_n) begin
      if (!evgRst_n) begin
         hb_interval_q <= '1;
         hb_ext_q      <= '0;
         hb_out_q      <= 1'b0;
      end else begin
         hb_interval_q <= hb_interval_d;
         hb_ext_q      <= hb_ext_d;
         hb_out_q      <= hb_out_d;
      end
   end

   // Two-stage synchronisers for the asynchronous external inputs
   always_ff @(posedge evgTxClk or negedge evgRst_n) begin
      if (!evgRst_n) begin
         ext_meta_q <= '0;
         ext_sync_q <= '0;
      end else begin
         ext_meta_q <= extIn_a;
         ext_sync_q <= ext_meta_q;
      end
   end

   // Readback mux; out-of-range addresses read as zero
   always_comb begin
      rd_d = '0;
      for (int unsigned i = 0; i < DISTRIBUTED_BUS_WIDTH; i++) begin
         if (cfgAddress == ADDR_WIDTH'(i)) begin
            rd_d = {ch_mode[i], ch_param[i]};
         end
      end
   end

   // Readback register
   always_ff @(posedge evgTxClk or negedge evgRst_n) begin
      if (!evgRst_n) begin
         rd_q <= '0;
      end else begin
         rd_q <= rd_d;
      end
   end

   for (genvar g = 0; g < DISTRIBUTED_BUS_WIDTH; g++) begin : g_ch
      logic wr_en_c;
      assign wr_en_c = cfgWriteStrobe && (cfgAddress == ADDR_WIDTH'(g));

      evg_dbus_channel #(
         .DIV_WIDTH       (DIV_WIDTH),
         .EXT_INPUT_COUNT (EXT_INPUT_COUNT)
      ) u_ch (
         .clk_i       (evgTxClk),
         .rst_ni      (evgRst_n),
         .wr_en_i     (wr_en_c),
         .wr_mode_i   (cfgWriteData[CFG_WIDTH-1 -: MODE_WIDTH]),
         .wr_param_i  (cfgWriteData[DIV_WIDTH-1:0]),
         .hb_out_i    (hb_out_q),
         .hb_strobe_i (evgHeartbeatRequest),
         .seq_start_i (evgSequenceStart),
         .ext_sync_i  (ext_sync_q),
         .cfg_mode_o  (ch_mode[g]),
         .cfg_param_o (ch_param[g]),
         .bus_o       (ch_bus[g])
      );
   end

   assign cfgReadData       = rd_q;
   assign evgDistributedBus = ch_bus;

endmodule

// File: tb/tb_evg_dbus_generator.sv
// Bench for evg_dbus_generator: directed scenarios plus random traffic,
// checked every cycle against a timestamp-based behavioural model.
module tb_evg_dbus_generator;

   localparam int unsigned W  = 8;
   localparam int unsigned DW = 24;
   localparam int unsigned NX = 4;
   localparam int unsigned CW = 3 + DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          hb = 1'b0;
   logic          seq = 1'b0;
   logic [NX-1:0] ext = '0;
   logic          wr = 1'b0;
   logic [4:0]    addr = '0;
   logic [CW-1:0] wdata = '0;
   logic [CW-1:0] rd;
   logic [W-1:0]  bus;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   evg_dbus_generator #(
      .DISTRIBUTED_BUS_WIDTH   (W),
      .TXCLK_NOMINAL_FREQUENCY (125000000),
      .DIV_WIDTH               (DW),
      .EXT_INPUT_COUNT         (NX)
   ) dut (
      .evgTxClk            (clk),
      .evgRst_n            (rst_n),
      .evgHeartbeatRequest (hb),
      .evgSequenceStart    (seq),
      .extIn_a             (ext),
      .cfgWriteStrobe      (wr),
      .cfgAddress          (addr),
      .cfgWriteData        (wdata),
      .cfgReadData         (rd),
      .evgDistributedBus   (bus)
   );

   // Reference model: events recorded as edge timestamps
   int            edge_n;
   logic [2:0]    m_mode [W];
   logic [DW-1:0] m_p    [W];
   int            m_wr   [W];
   int            hb_last, hb_start, hb_end, seq_last;
   logic [NX-1:0] m_ext_prev;
   logic [W-1:0]  m_state, m_bus_exp;
   logic [CW-1:0] m_rd_exp;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic div_phase(input int k, input int p);
      return (((k / (p + 1)) % 2) == 0);
   endfunction

   // Channel state after edge e, from config and event timestamps
   function automatic logic ch_state(input int i, input int e);
      int         p;
      logic [1:0] sel;
      p   = int'(m_p[i]);
      sel = 2'(m_p[i] % 24'(NX));
      case (m_mode[i])
         3'd0: return m_p[i][0];
         3'd1: return (e >= hb_start) && (e <= hb_end);
         3'd2: return (e == m_wr[i]) ? 1'b0 : div_phase(e - m_wr[i] - 1, p);
         3'd3: begin
            if (hb_last > m_wr[i]) return div_phase(e - hb_last, p);
            return (e == m_wr[i]) ? 1'b0 : div_phase(e - m_wr[i] - 1, p);
         end
         3'd4: return m_ext_prev[sel];
         3'd5: return (seq_last > m_wr[i]) && ((e - seq_last) <= p);
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < W; i++) begin
         m_mode[i] = '0;
         m_p[i]    = '0;
         m_wr[i]   = 0;
      end
      hb_last    = -1;
      hb_start   = 0;
      hb_end     = -1;
      seq_last   = -1;
      m_ext_prev = '0;
      m_state    = '0;
      m_bus_exp  = '0;
      m_rd_exp   = '0;
   endtask

   task automatic model_edge();
      int            e;
      logic [W-1:0]  nxt;
      edge_n++;
      e = edge_n;
      m_rd_exp = (32'(addr) < W) ? {m_mode[addr[2:0]], m_p[addr[2:0]]} : '0;
      if (wr && (32'(addr) < W)) begin
         m_mode[addr[2:0]] = wdata[CW-1:DW];
         m_p[addr[2:0]]    = wdata[DW-1:0];
         m_wr[addr[2:0]]   = e;
      end
      if (hb) begin
         if (hb_last >= 0) begin
            hb_start = e;
            hb_end   = e + (e - 1 - hb_last) / 2;
         end
         hb_last = e;
      end
      if (seq) seq_last = e;
      for (int i = 0; i < W; i++) nxt[i] = ch_state(i, e);
      m_bus_exp  = m_state;
      m_state    = nxt;
      m_ext_prev = ext;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("bus", 32'(bus), 32'(m_bus_exp));
      chk("rdback", 32'(rd), 32'(m_rd_exp));
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wr_cfg(input int a, input int mode, input int p);
      addr  = 5'(a);
      wdata = {3'(mode), 24'(p)};
      wr    = 1'b1;
      tick();
      wr    = 1'b0;
   endtask

   task automatic pulse_hb();
      hb = 1'b1;
      tick();
      hb = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_bus", 32'(bus), 32'd0);
      chk("rst_rd", 32'(rd), 32'd0);
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int cnt;
      edge_n = 0;
      model_reset();
      #2;
      apply_reset();

      // Readback of every address after reset, then an out-of-range write
      for (int a = 0; a < 10; a++) begin
         addr = 5'(a);
         tick();
      end
      wr_cfg(9, 2, 3);
      addr = 5'd9;
      run(4);
      chk("oob_bus", 32'(bus), 32'd0);
      chk("oob_rd", 32'(rd), 32'd0);

      // Heartbeat: first strobe silent, later ones stretched to half the interval
      wr_cfg(0, 1, 0);
      addr = 5'd0;
      pulse_hb();
      cnt = 0;
      repeat (999) begin tick(); cnt += int'(bus[0]); end
      chk("hb_first", 32'(cnt), 32'd0);
      pulse_hb();
      cnt = 0;
      repeat (600) begin tick(); cnt += int'(bus[0]); end
      chk("hb_len", 32'(cnt), 32'd500);
      run(399);
      pulse_hb();
      cnt = 0;
      repeat (600) begin tick(); cnt += int'(bus[0]); end
      chk("hb_len2", 32'(cnt), 32'd500);

      // Divider P=4 (5 high / 5 low), then rewrite mid-period
      wr_cfg(1, 2, 4);
      run(7);
      cnt = 0;
      repeat (20) begin tick(); cnt += int'(bus[1]); end
      chk("div_duty", 32'(cnt), 32'd10);
      run(2);
      wr_cfg(1, 2, 1);
      tick();
      chk("div_rewrite", 32'(bus[1]), 32'd0);
      cnt = 0;
      repeat (16) begin tick(); cnt += int'(bus[1]); end
      chk("div_p1", 32'(cnt), 32'd8);

      // Heartbeat-aligned divider: strobe on terminal count forces a fresh high phase
      wr_cfg(2, 3, 9);
      run(10);
      pulse_hb();
      cnt = 0;
      repeat (15) begin tick(); cnt += int'(bus[2]); end
      chk("dsync_hi", 32'(cnt), 32'd10);

      // Synchronised input: channel 3 follows extIn_a[2] only
      wr_cfg(3, 4, 2);
      ext[1] = 1'b1;
      run(5);
      chk("in_other", 32'(bus[3]), 32'd0);
      ext[2] = 1'b1;
      tick();
      tick();
      chk("in_lat2", 32'(bus[3]), 32'd0);
      tick();
      chk("in_lat3", 32'(bus[3]), 32'd1);
      ext = '0;
      run(4);

      // Sequence pulse with retrigger, then reset mid-pulse
      wr_cfg(4, 5, 7);
      cnt = 0;
      for (int k = 0; k < 26; k++) begin
         seq = (k == 0) || (k == 5);
         tick();
         cnt += int'(bus[4]);
      end
      seq = 1'b0;
      chk("seq_len", 32'(cnt), 32'd13);
      seq = 1'b1;
      tick();
      seq = 1'b0;
      run(3);
      chk("seq_active", 32'(bus[4]), 32'd1);
      apply_reset();

      // Random traffic with a mid-run reset
      for (int c = 0; c < 3000; c++) begin
         wr    = ($urandom_range(15) == 0);
         addr  = 5'($urandom_range(10));
         wdata = {3'($urandom_range(7)), 24'($urandom_range(7))};
         hb    = ($urandom_range(49) == 0);
         seq   = ($urandom_range(24) == 0);
         ext   = ext ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
         tick();
         if (c == 1500) begin
            wr  = 1'b0;
            hb  = 1'b0;
            seq = 1'b0;
            apply_reset();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
